serpent_key_schedule: RTL and testbench



---
 rtl/serpent_pkg.sv | 26 ++
 rtl/sboxes.sv | 52 +++++
 rtl/serpent_key_schedule.sv | 135 +++++++++++++
 tb/tb_serpent_key_schedule.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serpent_pkg.sv
// Shared constants and helpers for the Serpent key schedule:
// prekey constant, subkey count, key-length encodings and FSM states.
package serpent_pkg;

  localparam logic [31:0] PHI      = 32'h9E3779B9;
  localparam int          NUM_SUBK = 33;

  localparam logic [1:0] KEY_LEN_128 = 2'd0;
  localparam logic [1:0] KEY_LEN_192 = 2'd1;
  localparam logic [1:0] KEY_LEN_256 = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GEN  = 1'b1
  } state_e;

  function automatic logic [31:0] rol32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Subkey r runs through S-box (35 - r) mod 8, so K0 uses S3 and the sequence counts down.
  function automatic logic [2:0] sbox_index(input logic [5:0] r);
    return 3'((6'd35 - r) % 6'd8);
  endfunction

endpackage

// File: rtl/sboxes.sv
// Bitsliced Serpent S-box layer: bit b of word0..3 forms a nibble (word0 = LSB),
// which is substituted through S-box i_Sbox_index and scattered back into the words.
module sboxes (
  input  logic [31:0]  i_word0,
  input  logic [31:0]  i_word1,
  input  logic [31:0]  i_word2,
  input  logic [31:0]  i_word3,
  input  logic [2:0]   i_Sbox_index,
  output logic [127:0] o_data
);

  // Each row packs S[n] into nibble n (entry 0 in the low nibble).
  function automatic logic [63:0] sbox_row(input logic [2:0] idx);
    logic [63:0] row;
    case (idx)
      3'd0:    row = 64'hC90724DEB56A1F83;
      3'd1:    row = 64'h43D68EB1A50972CF;
      3'd2:    row = 64'h25B04E1DFAC39768;
      3'd3:    row = 64'hE57A421D369C8BF0;
      3'd4:    row = 64'hD7E9A4526B0C38F1;
      3'd5:    row = 64'h176D8E30C9A4B25F;
      3'd6:    row = 64'h0A3DF19EB6485C27;
      default: row = 64'h6539AC47B28E0FD1;
    endcase
    return row;
  endfunction

  logic [63:0] row;
  logic [3:0]  nib;
  logic [3:0]  sub;
  logic [31:0] y0, y1, y2, y3;

  always_comb begin
    row = sbox_row(i_Sbox_index);
    nib = '0;
    sub = '0;
    y0  = '0;
    y1  = '0;
    y2  = '0;
    y3  = '0;
    for (int b = 0; b < 32; b++) begin
      nib   = {i_word3[b], i_word2[b], i_word1[b], i_word0[b]};
      sub   = row[{nib, 2'b00} +: 4];
      y0[b] = sub[0];
      y1[b] = sub[1];
      y2[b] = sub[2];
      y3[b] = sub[3];
    end
    o_data = {y3, y2, y1, y0};
  end

endmodule

// File: rtl/serpent_key_schedule.sv
// Iterative Serpent key schedule: pads the user key, expands four prekey words per step
// from an 8-word sliding window and streams subkeys K0..K32 over valid/ready.
module serpent_key_schedule
  import serpent_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [255:0] i_key,
  input  logic [1:0]   i_key_len,
  input  logic         i_key_valid,
  output logic         o_key_ready,
  output logic [127:0] o_subkey,
  output logic [5:0]   o_subkey_idx,
  output logic         o_subkey_valid,
  input  logic         i_subkey_ready,
  output logic         o_done
);

  state_e              state_q, state_d;
  logic [7:0][31:0]    win_q, win_d;
  logic [5:0]          r_q, r_d;
  logic [127:0]        subkey_q, subkey_d;
  logic [5:0]          idx_q, idx_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;

  logic [255:0]        padded_key;
  logic [11:0][31:0]   w_ext;
  logic [31:0]         j_word;
  logic [127:0]        sbox_out;
  logic                advance;

  // Short keys get a single 1 bit just above their MSB; anything above it is cleared.
  always_comb begin
    padded_key = i_key;
    case (i_key_len)
      KEY_LEN_128: begin
        padded_key[255:128] = '0;
        padded_key[128]     = 1'b1;
      end
      KEY_LEN_192: begin
        padded_key[255:192] = '0;
        padded_key[192]     = 1'b1;
      end
      default: padded_key = i_key;
    endcase
  end

  // w_ext[0..7] = w[j-8..j-1] from the window; w_ext[8..11] = w[j..j+3] chained in one cycle.
  always_comb begin
    j_word = {24'd0, r_q, 2'b00};
    w_ext  = '0;
    for (int k = 0; k < 8; k++) begin
      w_ext[k] = win_q[k];
    end
    for (int m = 0; m < 4; m++) begin
      w_ext[8 + m] = rol32(w_ext[m] ^ w_ext[m + 3] ^ w_ext[m + 5] ^ w_ext[m + 7] ^
                           PHI ^ (j_word + 32'(m)), 11);
    end
  end

  sboxes u_sboxes (
    .i_word0      (w_ext[8]),
    .i_word1      (w_ext[9]),
    .i_word2      (w_ext[10]),
    .i_word3      (w_ext[11]),
    .i_Sbox_index (sbox_index(r_q)),
    .o_data       (sbox_out)
  );

  assign advance = !valid_q || i_subkey_ready;

  // Once r reaches NUM_SUBK the last subkey is parked in the output register until taken.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    r_d      = r_q;
    subkey_d = subkey_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_key_valid) begin
          win_d   = padded_key;
          r_d     = '0;
          state_d = ST_GEN;
        end
      end
      ST_GEN: begin
        if (advance) begin
          if (r_q < 6'(NUM_SUBK)) begin
            subkey_d = sbox_out;
            idx_d    = r_q;
            valid_d  = 1'b1;
            win_d    = w_ext[11:4];
            r_d      = r_q + 6'd1;
          end else begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      win_q    <= '0;
      r_q      <= '0;
      subkey_q <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      r_q      <= r_d;
      subkey_q <= subkey_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  assign o_key_ready    = (state_q == ST_IDLE);
  assign o_subkey       = subkey_q;
  assign o_subkey_idx   = idx_q;
  assign o_subkey_valid = valid_q;
  assign o_done         = done_q;

endmodule

// File: tb/tb_serpent_key_schedule.sv
// Self-checking bench for serpent_key_schedule: a prekey/S-box model computes every subkey
// from the key, and a negedge process compares the DUT stream against it each cycle.
module tb_serpent_key_schedule;

  localparam logic [31:0] PHI = 32'h9E3779B9;

  logic         clk;
  logic         rst_n;
  logic [255:0] i_key;
  logic [1:0]   i_key_len;
  logic         i_key_valid;
  logic         o_key_ready;
  logic [127:0] o_subkey;
  logic [5:0]   o_subkey_idx;
  logic         o_subkey_valid;
  logic         i_subkey_ready;
  logic         o_done;

  int checks = 0;
  int errors = 0;

  int sbt [8][16] = '{
    '{ 3,  8, 15,  1, 10,  6,  5, 11, 14, 13,  4,  2,  7,  0,  9, 12},
    '{15, 12,  2,  7,  9,  0,  5, 10,  1, 11, 14,  8,  6, 13,  3,  4},
    '{ 8,  6,  7,  9,  3, 12, 10, 15, 13,  1, 14,  4,  0, 11,  5,  2},
    '{ 0, 15, 11,  8, 12,  9,  6,  3, 13,  1,  2,  4, 10,  7,  5, 14},
    '{ 1, 15,  8,  3, 12,  0, 11,  6,  2,  5,  4, 10,  9, 14,  7, 13},
    '{15,  5,  2, 11,  4, 10,  9, 12,  0,  3, 14,  8, 13,  6,  7,  1},
    '{ 7,  2, 12,  5,  8,  4,  6, 11, 14,  9,  1, 15, 13,  3, 10,  0},
    '{ 1, 13, 15,  0, 14,  8,  2, 11,  7,  4, 12, 10,  9,  3,  5,  6}
  };

  logic [127:0] exp_k [33];
  logic [31:0]  m_w0;
  bit           m_idle  = 1'b1;
  bit           m_first = 1'b0;
  bit           m_done  = 1'b0;
  int           m_idx   = 0;
  int           hs_cnt  = 0;

  serpent_key_schedule dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_key          (i_key),
    .i_key_len      (i_key_len),
    .i_key_valid    (i_key_valid),
    .o_key_ready    (o_key_ready),
    .o_subkey       (o_subkey),
    .o_subkey_idx   (o_subkey_idx),
    .o_subkey_valid (o_subkey_valid),
    .i_subkey_ready (i_subkey_ready),
    .o_done         (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s at %0t: actual=%h expected=%h", name, $time, act, expv);
    end
  endtask

  function automatic logic [127:0] model_sbox(input logic [31:0] a0, input logic [31:0] a1,
                                              input logic [31:0] a2, input logic [31:0] a3,
                                              input int idx);
    logic [31:0] y0, y1, y2, y3;
    int n, v;
    y0 = '0; y1 = '0; y2 = '0; y3 = '0;
    for (int b = 0; b < 32; b++) begin
      n = 8 * int'(a3[b]) + 4 * int'(a2[b]) + 2 * int'(a1[b]) + int'(a0[b]);
      v = sbt[idx][n];
      y0[b] = v[0]; y1[b] = v[1]; y2[b] = v[2]; y3[b] = v[3];
    end
    return {y3, y2, y1, y0};
  endfunction

  // Pad, expand the full prekey sequence w[-8..131] (stored at offset 8), then derive K0..K32.
  task automatic model_build(input logic [255:0] key, input logic [1:0] len);
    logic [255:0] p;
    logic [31:0]  w [140];
    logic [31:0]  t;
    p = key;
    if (len == 2'd0) begin p[255:128] = '0; p[128] = 1'b1; end
    else if (len == 2'd1) begin p[255:192] = '0; p[192] = 1'b1; end
    for (int i = 0; i < 8; i++) w[i] = p[32*i +: 32];
    for (int i = 8; i < 140; i++) begin
      t    = w[i-8] ^ w[i-5] ^ w[i-3] ^ w[i-1] ^ PHI ^ 32'(i - 8);
      w[i] = {t[20:0], t[31:21]};
    end
    m_w0 = w[8];
    for (int r = 0; r < 33; r++)
      exp_k[r] = model_sbox(w[4*r+8], w[4*r+9], w[4*r+10], w[4*r+11], (35 - r) % 8);
  endtask

  // Compare process: outputs checked every cycle, then the model steps to the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_key_ready", 128'(o_key_ready), 128'd1);
      checkOutput("rst_valid", 128'(o_subkey_valid), 128'd0);
      checkOutput("rst_done", 128'(o_done), 128'd0);
      checkOutput("rst_subkey", o_subkey, 128'd0);
      checkOutput("rst_idx", 128'(o_subkey_idx), 128'd0);
      m_idle = 1'b1; m_first = 1'b0; m_done = 1'b0; m_idx = 0; hs_cnt = 0;
    end else begin
      checkOutput("key_ready", 128'(o_key_ready), 128'(m_idle));
      checkOutput("subkey_valid", 128'(o_subkey_valid), 128'(!m_idle && !m_first));
      checkOutput("done", 128'(o_done), 128'(m_done));
      if (!m_idle && !m_first) begin
        checkOutput("subkey_idx", 128'(o_subkey_idx), 128'(m_idx));
        checkOutput("subkey", o_subkey, exp_k[m_idx]);
      end
      if (m_done) begin
        checkOutput("subkey_count", 128'(hs_cnt), 128'd33);
        hs_cnt = 0;
      end
      if (o_subkey_valid && i_subkey_ready) hs_cnt++;
      m_done = 1'b0;
      if (m_idle) begin
        if (i_key_valid) begin
          model_build(i_key, i_key_len);
          m_idle = 1'b0; m_first = 1'b1; m_idx = 0;
        end
      end else if (m_first) begin
        m_first = 1'b0;
      end else if (i_subkey_ready) begin
        if (m_idx == 32) begin
          m_idle = 1'b1; m_done = 1'b1;
        end else begin
          m_idx++;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [255:0] key, input logic [1:0] len, input bit hold);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    i_key = key; i_key_len = len; i_key_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (!m_idle) begin ok = 1'b1; break; end
    end
    if (!ok) checkOutput("key_accept_timeout", 128'd0, 128'd1);
    if (!hold) i_key_valid = 1'b0;
  endtask

  task automatic waitIdle(input int mode, input int budget);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      i_subkey_ready = (mode == 1) ? (c % 2 == 0) : 1'b1;
      @(posedge clk); #1;
      if (m_idle) begin ok = 1'b1; break; end
    end
    i_subkey_ready = 1'b1;
    if (!ok) checkOutput("stream_timeout", 128'd0, 128'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit hit;
    rst_n = 1'b0; i_key = '0; i_key_len = 2'd2; i_key_valid = 1'b0; i_subkey_ready = 1'b1;

    model_build(256'd0, 2'd2);
    checkOutput("model_w0_zero_key", 128'(m_w0), 128'(32'hBBCDCCF1));
    checkOutput("model_s0_zero", model_sbox('0, '0, '0, '0, 0),
                {32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF});
    checkOutput("model_s7_ones", model_sbox('1, '1, '1, '1, 7),
                {32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0});

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] test 1: 256b zero key, latency and full stream");
    applyStimulus(256'd0, 2'd2, 1'b0);
    checkOutput("k0_latency_not_yet", 128'(o_subkey_valid), 128'd0);
    @(posedge clk); #1;
    checkOutput("k0_latency_valid", 128'(o_subkey_valid), 128'd1);
    checkOutput("k0_latency_idx", 128'(o_subkey_idx), 128'd0);
    waitIdle(0, 100);

    $display("[TB] test 2: 128b key with junk above bit 127");
    applyStimulus({128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF,
                   128'h00010203_04050607_08090A0B_0C0D0E0F}, 2'd0, 1'b0);
    waitIdle(0, 100);

    $display("[TB] test 3: 192b key, ready toggling");
    applyStimulus({64'hFFFF0000_FFFF0000, 192'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0_11223344_55667788},
                  2'd1, 1'b0);
    waitIdle(1, 200);

    $display("[TB] test 4: key offer held through stream");
    applyStimulus(256'h01234567_89ABCDEF_FEDCBA98_76543210_A5A5A5A5_5A5A5A5A_13579BDF_2468ACE0,
                  2'd2, 1'b1);
    i_key = {128'h0, 128'h80000000_00000001_FFFFFFFF_12345678};
    i_key_len = 2'd0;
    waitIdle(0, 100);
    checkOutput("held_offer_done_cycle", 128'(o_done), 128'd1);
    hit = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (!m_idle) begin hit = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!hit) checkOutput("held_offer_accept_timeout", 128'd0, 128'd1);
    i_key_valid = 1'b0;
    waitIdle(0, 100);

    $display("[TB] test 5: reset at idx 17");
    applyStimulus(256'hC0FFEE00_11111111_22222222_33333333_44444444_55555555_66666666_77777777,
                  2'd2, 1'b0);
    hit = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (o_subkey_valid && o_subkey_idx == 6'd17) begin hit = 1'b1; break; end
    end
    if (!hit) checkOutput("idx17_timeout", 128'd0, 128'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 128'(o_subkey_valid), 128'd0);
    checkOutput("async_rst_idx", 128'(o_subkey_idx), 128'd0);
    checkOutput("async_rst_subkey", o_subkey, 128'd0);
    checkOutput("async_rst_key_ready", 128'(o_key_ready), 128'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    applyStimulus(256'd0, 2'd2, 1'b0);
    waitIdle(0, 100);

    $display("[TB] test 6: key_len 3 treated as 256b");
    applyStimulus(256'h01234567_89ABCDEF_FEDCBA98_76543210_A5A5A5A5_5A5A5A5A_13579BDF_2468ACE0,
                  2'd3, 1'b0);
    waitIdle(0, 100);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
